// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: states, opcodes, funct codes, ALU F codes.
// MIPS_BLEZ_EN adds the BLEZEX state and its control decode.
package mips_pkg;

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTYPEEX = 4'd6,
    S_RTYPEWB = 4'd7,
    S_BEQEX   = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JEX     = 4'd11,
    S_BLEZEX  = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b1010;
  localparam logic [3:0] ALU_SLT = 4'b1011;
  localparam logic [3:0] ALU_SLL = 4'b0100;

  localparam logic [1:0] AOP_ADD = 2'b00;
  localparam logic [1:0] AOP_SUB = 2'b01;
  localparam logic [1:0] AOP_FN  = 2'b10;

  typedef struct packed {
    logic       pcwrite;
    logic       branch;
    logic       blez;
    logic       memwrite;
    logic       iord;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore decode: control word asserted while the FSM sits in state s.
  function automatic ctrl_t ctrl_of(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH:   begin c.irwrite = 1'b1; c.pcwrite = 1'b1; c.alusrcb = 2'b01; end
      S_DECODE:  c.alusrcb = 2'b11;
      S_MEMADR,
      S_ADDIEX:  begin c.alusrca = 1'b1; c.alusrcb = 2'b10; end
      S_MEMRD:   c.iord = 1'b1;
      S_MEMWB:   begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_MEMWR:   begin c.memwrite = 1'b1; c.iord = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = AOP_FN; end
      S_RTYPEWB: begin c.regwrite = 1'b1; c.regdst = 1'b1; end
      S_BEQEX:   begin c.alusrca = 1'b1; c.aluop = AOP_SUB; c.pcsrc = 2'b01; c.branch = 1'b1; end
      S_ADDIWB:  c.regwrite = 1'b1;
      S_JEX:     begin c.pcsrc = 2'b10; c.pcwrite = 1'b1; end
`ifdef MIPS_BLEZ_EN
      S_BLEZEX:  begin c.alusrca = 1'b1; c.aluop = AOP_SUB; c.pcsrc = 2'b01; c.blez = 1'b1; end
`endif
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU F-code decode from aluop and the R-type funct field.
module alu_decoder
  import mips_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      AOP_ADD: alucontrol = ALU_ADD;
      AOP_SUB: alucontrol = ALU_SUB;
      AOP_FN: begin
        case (funct)
          FN_ADD:  alucontrol = ALU_ADD;
          FN_SUB:  alucontrol = ALU_SUB;
          FN_AND:  alucontrol = ALU_AND;
          FN_OR:   alucontrol = ALU_OR;
          FN_SLT:  alucontrol = ALU_SLT;
          FN_SLL:  alucontrol = ALU_SLL;
          // unknown funct still adds; the writeback happens regardless
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_mc_controller.sv
// Multicycle MIPS control FSM; control word registered alongside state.
// MIPS_BLEZ_EN enables the BLEZ instruction (state 12), otherwise op 000110 is a NOP.
module mips_mc_controller
  import mips_pkg::*;
#(
  parameter logic [3:0] RESET_STATE = 4'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       ltez,
  output logic       pcen,
  output logic       memwrite,
  output logic       iord,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] pcsrc,
  output logic [3:0] alucontrol,
  output logic [3:0] state_o
);

  state_t state, nxt;
  ctrl_t  c;

  always_comb begin
    nxt = S_FETCH;
    case (state)
      S_FETCH: nxt = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE:     nxt = S_RTYPEEX;
          OP_BEQ:       nxt = S_BEQEX;
          OP_ADDI:      nxt = S_ADDIEX;
          OP_J:         nxt = S_JEX;
`ifdef MIPS_BLEZ_EN
          OP_BLEZ:      nxt = S_BLEZEX;
`endif
          default:      nxt = S_FETCH;
        endcase
      end
      S_MEMADR:  nxt = (op == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:   nxt = S_MEMWB;
      S_RTYPEEX: nxt = S_RTYPEWB;
      S_ADDIEX:  nxt = S_ADDIWB;
      default:   nxt = S_FETCH;
    endcase
  end

  // Control word tracks nxt so it changes in the same edge as state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= state_t'(RESET_STATE);
      c     <= ctrl_of(state_t'(RESET_STATE));
    end else begin
      state <= nxt;
      c     <= ctrl_of(nxt);
    end
  end

  alu_decoder u_alu_dec (
    .aluop      (c.aluop),
    .funct      (funct),
    .alucontrol (alucontrol)
  );

  assign pcen     = c.pcwrite | (c.branch & zero) | (c.blez & ltez);
  assign memwrite = c.memwrite;
  assign iord     = c.iord;
  assign irwrite  = c.irwrite;
  assign regdst   = c.regdst;
  assign memtoreg = c.memtoreg;
  assign regwrite = c.regwrite;
  assign alusrca  = c.alusrca;
  assign alusrcb  = c.alusrcb;
  assign pcsrc    = c.pcsrc;
  assign state_o  = state;

endmodule

// File: tb/tb_mips_mc_controller.sv
// Directed bench for mips_mc_controller: instruction sequences with hand-derived states/controls.
module tb_mips_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero, ltez;
  logic       pcen, memwrite, iord, irwrite, regdst, memtoreg, regwrite, alusrca;
  logic [1:0] alusrcb, pcsrc;
  logic [3:0] alucontrol, state_o;

  int checks = 0;
  int errors = 0;

  mips_mc_controller dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .ltez(ltez),
    .pcen(pcen), .memwrite(memwrite), .iord(iord), .irwrite(irwrite),
    .regdst(regdst), .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .pcsrc(pcsrc), .alucontrol(alucontrol), .state_o(state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_fetch(input string tag);
    chk({tag, ".state"}, 32'(state_o), 32'd0);
    chk({tag, ".irwrite"}, 32'(irwrite), 32'd1);
    chk({tag, ".pcen"}, 32'(pcen), 32'd1);
    chk({tag, ".alusrcb"}, 32'(alusrcb), 32'd1);
    chk({tag, ".alucontrol"}, 32'(alucontrol), 32'h2);
    chk({tag, ".wr"}, {30'd0, regwrite, memwrite}, 32'd0);
  endtask

  initial begin
    reset = 1'b1; op = 6'b100011; funct = 6'd0; zero = 1'b0; ltez = 1'b0;
    #1;
    chk_fetch("reset");
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // lw up to MEMRD, then reset mid-instruction
    chk_fetch("lw0");
    step(); chk("lw.decode", 32'(state_o), 32'd1);
    chk("lw.decode.alusrcb", 32'(alusrcb), 32'd3);
    chk("lw.decode.alucontrol", 32'(alucontrol), 32'h2);
    step(); chk("lw.memadr", 32'(state_o), 32'd2);
    chk("lw.memadr.ctl", {alusrca, alusrcb, alucontrol}, {1'b1, 2'b10, 4'b0010});
    step(); chk("lw.memrd", 32'(state_o), 32'd3);
    chk("lw.memrd.iord", 32'(iord), 32'd1);
    reset = 1'b1; #1;
    chk_fetch("midreset");
    @(negedge clk); reset = 1'b0;

    // full lw: 0,1,2,3,4,0
    step(); chk("lw2.decode", 32'(state_o), 32'd1);
    step(); chk("lw2.memadr", 32'(state_o), 32'd2);
    step(); chk("lw2.memrd", 32'(state_o), 32'd3);
    step(); chk("lw2.memwb", 32'(state_o), 32'd4);
    chk("lw2.memwb.ctl", {regwrite, memtoreg, regdst, memwrite}, 4'b1100);
    step(); chk_fetch("lw2.end");

    // R-type slt then sll
    op = 6'b000000; funct = 6'b101010;
    step(); chk("slt.decode", 32'(state_o), 32'd1);
    step(); chk("slt.ex", 32'(state_o), 32'd6);
    chk("slt.alucontrol", 32'(alucontrol), 32'hb);
    step(); chk("slt.wb", 32'(state_o), 32'd7);
    chk("slt.wb.ctl", {regwrite, regdst, memtoreg}, 3'b110);
    step(); chk_fetch("slt.end");
    funct = 6'b000000;
    step(); step(); chk("sll.ex", 32'(state_o), 32'd6);
    chk("sll.alucontrol", 32'(alucontrol), 32'h4);
    funct = 6'b100100; #1;
    chk("and.alucontrol", 32'(alucontrol), 32'h0);
    funct = 6'b100101; #1;
    chk("or.alucontrol", 32'(alucontrol), 32'h1);
    funct = 6'b111111; #1;
    chk("badfn.alucontrol", 32'(alucontrol), 32'h2);
    step(); chk("badfn.wb.regwrite", 32'(regwrite), 32'd1);
    step(); chk_fetch("rtype.end");

    // beq taken then not taken
    op = 6'b000100; zero = 1'b1;
    step(); step(); chk("beqt.state", 32'(state_o), 32'd8);
    chk("beqt.ctl", {pcen, pcsrc, alusrca, alusrcb, alucontrol}, {1'b1, 2'b01, 1'b1, 2'b00, 4'b1010});
    step(); chk_fetch("beqt.end");
    zero = 1'b0;
    step(); step(); chk("beqn.state", 32'(state_o), 32'd8);
    chk("beqn.pcen", 32'(pcen), 32'd0);
    step(); chk_fetch("beqn.end");

    // blez with ltez=1
    op = 6'b000110; ltez = 1'b1;
    step(); chk("blez.decode.pcen", 32'(pcen), 32'd0);
`ifdef MIPS_BLEZ_EN
    step(); chk("blez.state", 32'(state_o), 32'd12);
    chk("blez.ctl", {pcen, pcsrc, alucontrol}, {1'b1, 2'b01, 4'b1010});
    ltez = 1'b0; #1;
    chk("blez.nottaken.pcen", 32'(pcen), 32'd0);
`endif
    step(); chk_fetch("blez.end");
    ltez = 1'b0;

    // illegal opcode
    op = 6'b111111;
    step(); chk("ill.decode", {28'd0, state_o}, 32'd1);
    chk("ill.wr", {30'd0, regwrite, memwrite}, 32'd0);
    step(); chk_fetch("ill.end");

    // sw: 0,1,2,5,0
    op = 6'b101011;
    step(); step(); chk("sw.memadr", 32'(state_o), 32'd2);
    step(); chk("sw.memwr", 32'(state_o), 32'd5);
    chk("sw.ctl", {memwrite, iord, regwrite}, 3'b110);
    step(); chk_fetch("sw.end");

    // addi: 0,1,9,10,0
    op = 6'b001000;
    step(); step(); chk("addi.ex", 32'(state_o), 32'd9);
    chk("addi.ex.ctl", {alusrca, alusrcb, alucontrol}, {1'b1, 2'b10, 4'b0010});
    step(); chk("addi.wb", 32'(state_o), 32'd10);
    chk("addi.wb.ctl", {regwrite, regdst, memtoreg}, 3'b100);
    step(); chk_fetch("addi.end");

    // j: 0,1,11,0
    op = 6'b000010;
    step(); step(); chk("j.state", 32'(state_o), 32'd11);
    chk("j.ctl", {pcen, pcsrc}, 3'b110);
    step(); chk_fetch("j.end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
